// File: rtl/bcd_timer_core.sv
// mm:ss BCD timer engine: digit editor, countdown, count-up stopwatch, finish alarm.
// Latency: every output is registered, so a pulse or tick at edge N is visible in cycle N+1.
// Backpressure: none; the inputs are one-cycle pulses that take effect on the next clock edge.
module bcd_timer_core #(
    parameter int TICK_DIV     = 50000000,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        pressed,
    input  logic        mode,
    output logic [15:0] disp_bcd,
    output logic [2:0]  select,
    output logic [1:0]  state,
    output logic        paused,
    output logic        finish
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    // Per-digit upper limits, index 0 = s1 ... index 3 = m2; also the maximum time.
    localparam logic [3:0][3:0] LIM       = {4'(MIN_TENS_MAX), 4'd9, 4'd5, 4'd9};

    typedef enum logic [1:0] {
        S_CFG  = 2'd0,
        S_DOWN = 2'd1,
        S_UP   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [3:0][3:0] cfg_q, cfg_d;
    logic [3:0][3:0] run_q, run_d;
    logic            paused_q, paused_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic [16:0]     cfg_inc;
    logic [16:0]     run_inc;
    logic [15:0]     run_dec;
    logic [1:0]      dig;

    // Increment starting at digit 'from' with the carry chain; bit 16 flags overflow past the top digit.
    function automatic logic [16:0] bcd_inc(input logic [3:0][3:0] v, input int from);
        logic [3:0][3:0] r;
        logic            c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= from && c) begin
                if (v[i] == LIM[i]) begin
                    r[i] = 4'd0;
                end else begin
                    r[i] = v[i] + 4'd1;
                    c    = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Decrement by one second with borrow; only used while the run value is nonzero.
    function automatic logic [15:0] bcd_dec(input logic [3:0][3:0] v);
        logic [3:0][3:0] r;
        logic            b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[i] == 4'd0) begin
                    r[i] = LIM[i];
                end else begin
                    r[i] = v[i] - 4'd1;
                    b    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign select = sel_q;
    assign state  = state_q;
    assign paused = paused_q;

    // Next-state logic: editing in CFG, ticking in DOWN/UP, acknowledge in DONE.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cfg_d    = cfg_q;
        run_d    = run_q;
        paused_d = paused_q;
        presc_d  = presc_q;
        dig      = sel_q[1:0];
        cfg_inc  = bcd_inc(cfg_q, int'(sel_q));
        run_inc  = bcd_inc(run_q, 0);
        run_dec  = bcd_dec(run_q);
        tick     = !paused_q && (presc_q == TICK_LAST);

        case (state_q)
            S_CFG: begin
                if (pressed) begin
                    // A start press takes priority; a refused start still swallows edits.
                    if (mode) begin
                        state_d = S_UP;
                        run_d   = '0;
                        presc_d = '0;
                    end else if (sel_q == 3'd4 && cfg_q != '0) begin
                        state_d = S_DOWN;
                        run_d   = cfg_q;
                        presc_d = '0;
                    end
                end else begin
                    if (left) begin
                        sel_d = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
                    end else if (right) begin
                        sel_d = (sel_q == 3'd0) ? 3'd4 : sel_q - 3'd1;
                    end
                    if (sel_q != 3'd4) begin
                        if (up) begin
                            // Overflow past the top digit cancels the whole edit.
                            if (!cfg_inc[16]) begin
                                cfg_d = cfg_inc[15:0];
                            end
                        end else if (down && cfg_q[dig] != 4'd0) begin
                            cfg_d[dig] = cfg_q[dig] - 4'd1;
                        end
                    end
                end
            end
            S_DOWN, S_UP: begin
                if (!paused_q) begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                end
                if (tick) begin
                    if (state_q == S_DOWN) begin
                        run_d = run_dec;
                        if (run_dec == '0) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        run_d = run_inc[15:0];
                        if (run_inc[15:0] == LIM) begin
                            state_d = S_DONE;
                        end
                    end
                end
                if (pressed) begin
                    paused_d = !paused_q;
                end
            end
            default: begin
                if (pressed) begin
                    state_d  = S_CFG;
                    paused_d = 1'b0;
                end
            end
        endcase
    end

    // State registers; display and alarm are registered from the next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_CFG;
            sel_q    <= 3'd4;
            cfg_q    <= '0;
            run_q    <= '0;
            paused_q <= 1'b0;
            presc_q  <= '0;
            disp_bcd <= '0;
            finish   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cfg_q    <= cfg_d;
            run_q    <= run_d;
            paused_q <= paused_d;
            presc_q  <= presc_d;
            disp_bcd <= (state_d == S_CFG) ? cfg_d : run_d;
            finish   <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_bcd_timer_core.sv
// Self-checking bench for bcd_timer_core against a seconds-based reference model.
// Latency: outputs are compared #1 after every rising edge.
// Backpressure: none; inputs are single-cycle pulses.
module tb_bcd_timer_core;

    localparam int TD   = 4;
    localparam int MT   = 5;
    localparam int MAXS = MT * 600 + 599;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, pressed = 1'b0, mode = 1'b0;
    logic [15:0] disp_bcd;
    logic [2:0]  select;
    logic [1:0]  state;
    logic        paused;
    logic        finish;

    int checks = 0;
    int errors = 0;

    // Reference model: times are held as plain seconds.
    int mstate = 0;
    int msel   = 4;
    int mcfg   = 0;
    int mrun   = 0;
    int mpresc = 0;
    bit mpaused = 1'b0;

    bcd_timer_core #(.TICK_DIV(TD), .MIN_TENS_MAX(MT)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .pressed(pressed), .mode(mode), .disp_bcd(disp_bcd), .select(select),
        .state(state), .paused(paused), .finish(finish)
    );

    always #5 clk = ~clk;

    function automatic int wt(input int k);
        case (k)
            0: return 1;
            1: return 10;
            2: return 60;
            default: return 600;
        endcase
    endfunction

    function automatic int dg(input int v, input int k);
        case (k)
            0: return (v % 60) % 10;
            1: return (v % 60) / 10;
            2: return (v / 60) % 10;
            default: return v / 600;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(dg(v, 3)), 4'(dg(v, 2)), 4'(dg(v, 1)), 4'(dg(v, 0))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        mstate = 0; msel = 4; mcfg = 0; mrun = 0; mpresc = 0; mpaused = 1'b0;
    endtask

    task automatic mstep(input bit u, input bit d, input bit l, input bit r, input bit p, input bit mo);
        int  old;
        bit  tk;
        old = msel;
        case (mstate)
            0: begin
                if (p) begin
                    if (mo) begin
                        mstate = 2; mrun = 0; mpresc = 0;
                    end else if (msel == 4 && mcfg != 0) begin
                        mstate = 1; mrun = mcfg; mpresc = 0;
                    end
                end else begin
                    if (l) msel = (msel == 4) ? 0 : msel + 1;
                    else if (r) msel = (msel == 0) ? 4 : msel - 1;
                    if (old < 4) begin
                        if (u) begin
                            if (mcfg + wt(old) <= MAXS) mcfg = mcfg + wt(old);
                        end else if (d) begin
                            if (dg(mcfg, old) != 0) mcfg = mcfg - wt(old);
                        end
                    end
                end
            end
            1, 2: begin
                tk = !mpaused && (mpresc == TD - 1);
                if (!mpaused) mpresc = (mpresc + 1) % TD;
                if (tk) begin
                    if (mstate == 1) begin
                        mrun = mrun - 1;
                        if (mrun == 0) mstate = 3;
                    end else begin
                        mrun = mrun + 1;
                        if (mrun == MAXS) mstate = 3;
                    end
                end
                if (p) mpaused = !mpaused;
            end
            default: begin
                if (p) begin
                    mstate = 0; mpaused = 1'b0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("disp_bcd", disp_bcd, (mstate == 0) ? to_bcd(mcfg) : to_bcd(mrun));
        check("select", select, msel);
        check("state", state, mstate);
        check("paused", paused, mpaused);
        check("finish", finish, mstate == 3);
    endtask

    task automatic cyc(input bit u, input bit d, input bit l, input bit r, input bit p, input bit mo);
        up = u; down = d; left = l; right = r; pressed = p; mode = mo;
        @(posedge clk);
        mstep(u, d, l, r, p, mo);
        #1;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; pressed = 1'b0; mode = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cur_to(input int s);
        for (int i = 0; i < 5 && msel != s; i++) cyc(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_disp", disp_bcd, 16'h0000);
        check("rst_select", select, 4);
        check("rst_select4", select, 4);
        check("rst_state", state, 0);
        check("rst_finish", finish, 0);
        check("rst_paused", paused, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cursor wrap and no-borrow down
        cyc(0, 0, 0, 1, 0, 0);
        check("right_from_4", select, 3'd3);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("left_wrap", select, 3'd0);
        cyc(0, 1, 0, 0, 0, 0);
        check("down_at_zero", disp_bcd, 16'h0000);

        // Carry chain: 00:59 + 1 s -> 01:00
        repeat (9) cyc(1, 0, 0, 0, 0, 0);
        cur_to(1);
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        cur_to(0);
        check("cfg_0059", disp_bcd, 16'h0059);
        cyc(1, 0, 0, 0, 0, 0);
        check("carry_0100", disp_bcd, 16'h0100);

        // Build 59:59, then an overflowing edit must be ignored
        cur_to(3); repeat (5) cyc(1, 0, 0, 0, 0, 0);
        cur_to(2); repeat (8) cyc(1, 0, 0, 0, 0, 0);
        cur_to(3); cur_to(1); repeat (5) cyc(1, 0, 0, 0, 0, 0);
        cur_to(2); cur_to(0); repeat (9) cyc(1, 0, 0, 0, 0, 0);
        check("cfg_max", disp_bcd, 16'h5959);
        cyc(1, 0, 0, 0, 0, 0);
        check("cfg_max_hold", disp_bcd, 16'h5959);
        cur_to(3); cyc(1, 0, 0, 0, 0, 0);
        check("cfg_max_hold_m2", disp_bcd, 16'h5959);

        // Random editing in CFG
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0, 1'b0);

        // Clear config, zero-start guard
        for (int k = 0; k < 4; k++) begin
            cur_to(k);
            repeat (10) cyc(0, 1, 0, 0, 0, 0);
        end
        cur_to(4);
        check("cfg_cleared", disp_bcd, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0);
        check("zero_start_guard", state, 2'd0);

        // Config 01:01; start refused away from confirm, accepted at confirm
        cur_to(2); cyc(1, 0, 0, 0, 0, 0);
        cur_to(0); cyc(1, 0, 0, 0, 0, 0);
        cur_to(2);
        cyc(0, 0, 0, 0, 1, 0);
        check("sel_start_guard", state, 2'd0);
        cur_to(4);
        cyc(0, 0, 0, 0, 1, 0);
        check("down_started", state, 2'd1);
        check("down_initial", disp_bcd, 16'h0101);
        idle(4);
        check("down_4cyc", disp_bcd, 16'h0100);
        idle(4);
        check("down_8cyc", disp_bcd, 16'h0059);
        n = 0;
        while (mstate != 3 && n < 1000) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b0, 1'b0);
            n++;
        end
        check("down_done_bound", n < 1000, 1);
        check("down_done_state", state, 2'd3);
        check("down_done_finish", finish, 1'b1);
        check("down_done_disp", disp_bcd, 16'h0000);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0, 1);
        check("done_ignores", disp_bcd, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0);
        check("ack_state", state, 2'd0);
        check("ack_finish", finish, 1'b0);
        check("cfg_retained", disp_bcd, 16'h0101);

        // Count-up, pause at 00:03 on the tick edge
        cur_to(1);
        cyc(0, 0, 0, 0, 1, 1);
        check("up_started", state, 2'd2);
        n = 0;
        while (!(mrun == 2 && mpresc == TD - 1) && n < 100) begin
            idle(1);
            n++;
        end
        cyc(0, 0, 0, 0, 1, 0);
        check("pause_val", disp_bcd, 16'h0003);
        check("pause_flag", paused, 1'b1);
        idle(10);
        check("pause_hold", disp_bcd, 16'h0003);
        cyc(0, 0, 0, 0, 1, 0);
        check("resume_flag", paused, 1'b0);
        idle(TD - 1);
        check("resume_no_tick", disp_bcd, 16'h0003);
        idle(1);
        check("resume_tick", disp_bcd, 16'h0004);
        n = 0;
        while (mstate != 3 && n < 16000) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b0, 1'b0);
            n++;
        end
        check("up_done_bound", n < 16000, 1);
        check("up_done_state", state, 2'd3);
        check("up_done_disp", disp_bcd, 16'h5959);
        idle(6);
        check("up_held", disp_bcd, 16'h5959);
        cyc(0, 0, 0, 0, 1, 0);
        check("up_ack", state, 2'd0);

        // Asynchronous reset in the middle of a countdown
        cur_to(4);
        cyc(0, 0, 0, 0, 1, 0);
        idle(10);
        cyc(0, 0, 0, 0, 1, 0);
        check("pre_rst_paused", paused, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        mreset();
        check("arst_state", state, 2'd0);
        check("arst_disp", disp_bcd, 16'h0000);
        check("arst_select", select, 3'd4);
        check("arst_finish", finish, 1'b0);
        check("arst_paused", paused, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        cyc(0, 0, 0, 0, 1, 0);
        check("post_rst_guard", state, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_core.md
Name: bcd_timer_core

Overview:
Parametrised mm:ss BCD timer engine with an edit mode, a countdown mode and a count-up (stopwatch) mode. Digits are edited with up/down/left/right, and a run is started with pressed. A run can be paused and resumed. The block raises a finish alarm until the user acknowledges it. It drives the display/sprite memory through disp_bcd and select.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=2)
MIN_TENS_MAX, 5, maximum value of the minute-tens digit (1..9); maximum time is MIN_TENS_MAX9:59

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
up  input  1  one-cycle pulse, increment the selected digit
down  input  1  one-cycle pulse, decrement the selected digit
left  input  1  one-cycle pulse, move the cursor left
right  input  1  one-cycle pulse, move the cursor right
pressed  input  1  one-cycle pulse: start / pause / resume / acknowledge
mode  input  1  0 = countdown, 1 = count-up; sampled only on start
disp_bcd  output  16  {m2,m1,s2,s1}, 4 bits each: config value in CFG, run value otherwise
select  output  3  cursor: 0 = s1, 1 = s2, 2 = m1, 3 = m2, 4 = confirm
state  output  2  0 = CFG, 1 = DOWN, 2 = UP, 3 = DONE
paused  output  1  run is frozen
finish  output  1  alarm level, high exactly while state == DONE

Behaviour:
- Reset (async, any state, mid-run included): state=CFG, select=4, config digits=00:00, run digits=00:00, paused=0, prescaler=0, finish=0. All other logic is synchronous to the rising edge of clk.
- Priority between simultaneous pulses: left over right; up over down; pressed over digit edits in the same cycle.
- CFG, cursor:
  - left: select 4->0, else +1.
  - right: select 0->4, else -1.
- CFG, digit edit (select 0..3):
  - up: increments with carry chain s1(0-9) -> s2(0-5) -> m1(0-9) -> m2(0..MIN_TENS_MAX).
  - If the carry would push m2 above MIN_TENS_MAX, the whole edit is ignored and the value is unchanged.
  - down: decrements the selected digit only; a digit already at 0 stays at 0 (no borrow).
  - up/down with select=4 have no effect.
- Start from CFG:
  - pressed with mode=1 (any select): UP, run value := 00:00.
  - pressed with mode=0 and select=4 and config != 00:00: DOWN, run value := config.
  - pressed with mode=0 and config == 00:00, or with select != 4: ignored.
  - The config value is retained across runs.
- Prescaler:
  - Counts 0..TICK_DIV-1 in DOWN/UP while paused=0.
  - tick is asserted on the cycle the count equals TICK_DIV-1, and the count wraps to 0.
  - The prescaler is cleared on every entry to DOWN/UP; it holds while paused.
- DOWN: on tick, the run value decrements with borrow (s1 9<-0 borrows s2, s2 5<-0 borrows m1, m1 9<-0 borrows m2). The tick that makes the value 00:00 also moves state to DONE on the same edge.
- UP: on tick, the run value increments with the same carry chain. The tick that makes the value equal MIN_TENS_MAX9:59 moves state to DONE on the same edge; the value is held, with no wrap.
- Pause:
  - pressed in DOWN/UP toggles paused.
  - The run value and prescaler freeze while paused=1.
  - up/down/left/right are ignored in DOWN, UP and DONE.
- DONE:
  - finish=1 and disp_bcd shows the final run value.
  - pressed: state=CFG, paused=0, finish=0 on the next edge.
  - No other input has an effect.
- Latency: all outputs are registered. The tick at edge N changes disp_bcd and state at edge N, so they are visible in cycle N+1.
- Widths: prescaler width is $clog2(TICK_DIV). Digits are 4-bit BCD and never hold values above their limits.

Test Plan:
- Edit carry with MIN_TENS_MAX=5, select=0, config=00:59, up -> 01:00. At config=59:59, up -> unchanged 59:59.
- Cursor wrap: from reset, right -> select=3; left x2 -> 4 -> 0. At s1=0, down -> stays 00:00.
- Countdown with TICK_DIV=4, config=01:01, select=4, mode=0, pressed:
  - After 4 cycles -> 01:00; after 8 cycles -> 00:59.
  - After 61 ticks -> state=DONE, finish=1, 00:00.
  - pressed -> CFG with config still 01:01.
- Zero-start guard: config=00:00, select=4, mode=0, pressed -> remains CFG. With select=2 and nonzero config -> remains CFG.
- Count-up with MIN_TENS_MAX=1, TICK_DIV=2:
  - mode=1, pressed -> runs from 00:00; reaches 19:59 after 1199 ticks -> DONE, value held.
  - Pause at 00:03 for 10 cycles -> value stays 00:03; resume -> next tick arrives TICK_DIV cycles later.
- Async reset mid-DOWN (asserted between clock edges) -> immediately state=CFG, disp_bcd=0, select=4, finish=0, paused=0.
